// File: rtl/vga_sync_gen.sv
// VGA raster timing generator. Counts pixels/lines on each pixel strobe and
// registers sync, blanking, coordinates and a start-of-frame pulse from the
// pre-increment counter values, so all outputs are mutually aligned.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start
);

  // Sized copies of the timing constants so every compare is 10 bits wide.
  localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
  localparam logic [9:0] HS_BEG_C = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END_C = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST_C = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
  localparam logic [9:0] VS_BEG_C = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END_C = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST_C = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic [9:0] x_q, y_q;
  logic       frame_start_q, frame_start_d;

  // Next counter values and the output image of the current counter position.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST_C) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST_C) ? '0 : v_cnt_q + 10'd1;
    end else begin
      h_cnt_d = h_cnt_q + 10'd1;
    end
    video_on_d    = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    hsync_d       = ((h_cnt_q >= HS_BEG_C) && (h_cnt_q < HS_END_C)) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = ((v_cnt_q >= VS_BEG_C) && (v_cnt_q < VS_END_C)) ? SYNC_POL : ~SYNC_POL;
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // State and output registers: advance on strobe, hold otherwise; the
  // frame pulse is cleared on every non-strobe clock so it lasts one clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
    end else if (pix_en) begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      x_q           <= h_cnt_q;
      y_q           <= v_cnt_q;
      frame_start_q <= frame_start_d;
    end else begin
      frame_start_q <= 1'b0;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: a default 640x480 instance for reset, line, wrap, irregular
// strobe and mid-frame reset behaviour, plus a tiny-raster SYNC_POL=1
// instance so whole frames and vsync can be covered in a short run.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, pix_en;
  logic hs0, vs0, vo0, fs0;
  logic [9:0] x0, y0;
  logic hs1, vs1, vo1, fs1;
  logic [9:0] x1, y1;

  int errors = 0;
  int checks = 0;

  vga_sync_gen u0 (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync(hs0), .vsync(vs0), .video_on(vo0), .x(x0), .y(y0), .frame_start(fs0)
  );

  // Small raster: 8+2+3+2 = 15 pixels/line, 6+1+2+1 = 10 lines/frame.
  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1)
  ) u1 (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync(hs1), .vsync(vs1), .video_on(vo1), .x(x1), .y(y1), .frame_start(fs1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic pe);
    pix_en = pe;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] v0();
    return {8'd0, x0, y0, vo0, hs0, vs0, fs0};
  endfunction

  function automatic logic [31:0] v1();
    return {8'd0, x1, y1, vo1, hs1, vs1, fs1};
  endfunction

  // Expected outputs for the 640x480 active-low instance.
  function automatic logic [31:0] e0(input int mx, input int my, input bit fs);
    logic vo, hs, vs;
    vo = (mx < 640) && (my < 480);
    hs = !((mx >= 656) && (mx < 752));
    vs = !((my >= 490) && (my < 492));
    return {8'd0, 10'(mx), 10'(my), vo, hs, vs, fs};
  endfunction

  // Expected outputs for the small active-high instance.
  function automatic logic [31:0] e1(input int mx, input int my);
    logic vo, hs, vs, fs;
    vo = (mx < 8) && (my < 6);
    hs = (mx >= 10) && (mx < 13);
    vs = (my >= 7) && (my < 9);
    fs = (mx == 0) && (my == 0);
    return {8'd0, 10'(mx), 10'(my), vo, hs, vs, fs};
  endfunction

  initial begin
    int mx, my, vo_cnt, hs_cnt, hs_first, hs_last, gap, fs_cnt, fs_a, fs_b, vs_cnt;
    logic [31:0] last;

    // Reset, with a strobe during reset that must be ignored.
    rst = 1'b1; pix_en = 1'b0;
    step(1'b0);
    step(1'b1);
    chk("reset_u0", v0(), {8'd0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0});
    chk("reset_u1", v1(), {8'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;
    step(1'b0);
    chk("reset_hold", v0(), {8'd0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0});

    // First strobe: pixel (0,0) with frame_start for exactly one clk.
    step(1'b1);
    chk("first_pix", v0(), e0(0, 0, 1'b1));
    step(1'b0);
    chk("fs_one_clk", v0(), e0(0, 0, 1'b0));
    step(1'b0); step(1'b0);

    // Rest of line 0 at one strobe in four.
    vo_cnt = 1; hs_cnt = 0; hs_first = -1; hs_last = -1;
    for (int p = 1; p < 800; p++) begin
      step(1'b1);
      chk("line0", v0(), e0(p, 0, 1'b0));
      if (vo0) vo_cnt++;
      if (!hs0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(x0);
        hs_last = int'(x0);
      end
      step(1'b0); step(1'b0); step(1'b0);
    end
    chk("vo_count", vo_cnt, 640);
    chk("hs_count", hs_cnt, 96);
    chk("hs_first", hs_first, 656);
    chk("hs_last", hs_last, 751);
    step(1'b1);
    chk("line_wrap", v0(), e0(0, 1, 1'b0));

    // Irregular strobes including back-to-back; outputs hold in gaps.
    mx = 1; my = 1; last = e0(0, 1, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      gap = $urandom_range(0, 7);
      for (int g = 0; g < gap; g++) begin
        step(1'b0);
        chk("gap_hold", v0(), {last[31:1], 1'b0});
      end
      step(1'b1);
      last = e0(mx, my, (mx == 0) && (my == 0));
      chk("irregular", v0(), last);
      if (mx == 799) begin
        mx = 0;
        my = (my == 524) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end

    // Mid-frame reset coinciding with a strobe.
    rst = 1'b1;
    step(1'b1);
    chk("rst_mid", v0(), {8'd0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0});
    rst = 1'b0;
    step(1'b0);
    chk("rst_mid_hold", v0(), {8'd0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0});
    step(1'b1);
    chk("restart", v0(), e0(0, 0, 1'b1));

    // Small active-high raster: two full frames of back-to-back strobes.
    rst = 1'b1;
    step(1'b0);
    chk("u1_reset", v1(), {8'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;
    mx = 0; my = 0; fs_cnt = 0; fs_a = -1; fs_b = -1; vs_cnt = 0;
    for (int s = 0; s < 300; s++) begin
      step(1'b1);
      chk("small", v1(), e1(mx, my));
      if (fs1) begin
        fs_cnt++;
        if (fs_a < 0) fs_a = s; else fs_b = s;
      end
      if (vs1) vs_cnt++;
      if (mx == 14) begin
        mx = 0;
        my = (my == 9) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end
    chk("small_fs_count", fs_cnt, 2);
    chk("small_fs_period", fs_b - fs_a, 150);
    chk("small_vs_count", vs_cnt, 60);
    step(1'b0);
    chk("small_fs_drop", {31'd0, fs1}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
